key_schedule_ctrl: RTL

KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

---
 rtl/key_schedule_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/key_schedule_ctrl.sv
// rtl/key_schedule_ctrl.sv - AES-128 key schedule controller with a single reused round function

module keyexpansion (
    input  logic [127:0] key,
    input  logic [31:0]  rcon,
    output logic [127:0] key_o
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse (x^254, which also maps 0 to 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] w3_rot;
    logic [31:0] temp;
    logic [31:0] o0;
    logic [31:0] o1;
    logic [31:0] o2;
    logic [31:0] o3;

    always_comb begin
        w3_rot = {key[23:0], key[31:24]};
        temp   = {sbox(w3_rot[31:24]), sbox(w3_rot[23:16]),
                  sbox(w3_rot[15:8]),  sbox(w3_rot[7:0])} ^ rcon;
        o0     = key[127:96] ^ temp;
        o1     = key[95:64]  ^ o0;
        o2     = key[63:32]  ^ o1;
        o3     = key[31:0]   ^ o2;
        key_o  = {o0, o1, o2, o3};
    end

endmodule

module key_schedule_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data
);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    state_t       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [31:0]  rcon_q, rcon_d;
    logic         valid_q, valid_d;
    logic [127:0] rk_q [0:10];
    logic [127:0] rk_d [0:10];

    logic [127:0] ke_key;
    logic [127:0] ke_key_o;

    keyexpansion u_keyexpansion (
        .key   (ke_key),
        .rcon  (rcon_q),
        .key_o (ke_key_o)
    );

    // Round function always consumes the previous round key; explicit mux avoids an out-of-range index at round 0
    always_comb begin
        ke_key = '0;
        for (int i = 0; i < 10; i++) begin
            if (round_q == 4'(i + 1)) ke_key = rk_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        valid_d = valid_q;
        rk_d    = rk_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    rk_d[0] = key_in;
                    round_d = 4'd1;
                    rcon_d  = 32'h0100_0000;
                    valid_d = 1'b0;
                    state_d = EXPAND;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            EXPAND: begin
                for (int i = 1; i <= 10; i++) begin
                    if (round_q == 4'(i)) rk_d[i] = ke_key_o;
                end
                rcon_d  = {xtime(rcon_q[31:24]), 24'h0};
                round_d = round_q + 4'd1;
                if (round_q == 4'd10) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            rcon_q  <= 32'h0100_0000;
            valid_q <= 1'b0;
            for (int i = 0; i <= 10; i++) rk_q[i] <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            valid_q <= valid_d;
            for (int i = 0; i <= 10; i++) rk_q[i] <= rk_d[i];
        end
    end

    always_comb begin
        rk_data = '0;
        for (int i = 0; i <= 10; i++) begin
            if (rk_addr == 4'(i)) rk_data = rk_q[i];
        end
    end

    assign busy       = (state_q == EXPAND);
    assign done       = (state_q == DONE);
    assign keys_valid = valid_q;

endmodule
